rotate_arbiter: RTL
===================

// Module: rotate_arbiter
// PURPOSE
//  Shares one rotate datapath between two requesters (A=0, B=1).
//  Round-robin arbitration, one transaction in flight. Valid/ready handshake on each request and on the result.
//  Supports right and left rotation; left is mapped onto the right-rotate datapath.
//  Sits between the front-end request sources and the shared rotate unit. Also provides a completed-operation counter for status.
// PARAMETERS
//  DATA_W   8   rotate word width; must be a power of 2, >= 2
//  AMT_W    $clog2(DATA_W)   rotate amount width
//  COUNT_W  16  width of completed-operation counter
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  req_valid    in   2        per-requester request valid ([0]=A, [1]=B)
//  req_ready    out  2        per-requester accept; at most one bit high
//  req_data     in   2*DATA_W packed operands; A=[DATA_W-1:0]
//  req_amt      in   2*AMT_W  packed rotate amounts; A in low slice
//  req_dir      in   2        0=rotate right, 1=rotate left
//  res_valid    out  1        result valid
//  res_ready    in   1        result consumer ready
//  res_data     out  DATA_W   rotated word
//  res_id       out  1        requester that owns res_data
//  op_count     out  COUNT_W  completed result handshakes, wraps to 0
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0; res_valid=0; res_data=0; res_id=0; op_count=0; priority pointer favours A.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: grant = RR pick among req_valid. req_ready[grant] high in the same cycle (combinational from state, pointer, valid).
//    On accept, capture data, amt, dir and id into the operand register, then go to EXEC. With no valid, stay in IDLE.
//   EXEC: operand register feeds the rotate sub-module. Result is registered into res_data/res_id. Go to RESP.
//   RESP: res_valid=1. res_data and res_id are held stable until res_ready.
//    On res_valid&&res_ready: op_count++, the pointer moves to favour the other requester, go to IDLE.
//  req_ready=0 in EXEC and RESP; there is no input buffering.
//  Latency: accept at cycle N -> res_valid at cycle N+2. Maximum throughput is 1 operation per 3 cycles.
//  RR rule: if both are valid, grant the favoured one. If only one is valid, grant it regardless of the pointer.
//   The pointer changes only on a result handshake.
//  Effective right amount: dir=0 -> amt; dir=1 -> (DATA_W - amt) mod DATA_W, computed in AMT_W bits.
//   amt=0 passes data unchanged in both directions.
//  Requesters must hold valid, data, amt and dir stable until ready. A valid that drops before grant is simply not served.
//  op_count wraps from 2^COUNT_W-1 to 0 without a flag.
//  Async reset mid-EXEC/RESP: the in-flight transaction is discarded, all outputs return to reset values immediately, and nothing is replayed.
//  res_ready high while res_valid=0 has no effect.
// STRUCTURE
//  Package rotate_pkg: DATA_W/AMT_W defaults; typedef enum logic [1:0] {IDLE,EXEC,RESP} rot_state_t;
//   dir constants ROT_RIGHT=1'b0, ROT_LEFT=1'b1.
//  Sub-module rotate_right_stage: parameterised combinational log2 barrel rotator.
//   Stage k rotates right by 2^k when amt[k]=1. Instantiated once, in EXEC.
//  Arbiter, left-to-right amount mapping, FSM and counter stay in this module.
// TESTING
//  1 A: data=8'hB4 amt=3 dir=R -> req_ready[0] in the accept cycle; 2 cycles later res_data=8'h96, res_id=0.
//  2 B: data=8'h81 amt=1 dir=L -> res_data=8'h03, res_id=1. Also amt=0 in both directions -> data unchanged.
//  3 A and B valid in the same cycle after reset -> A served first, B next.
//    Both held continuously -> grants alternate A,B,A,B; op_count=4 after 4 handshakes.
//  4 res_ready low 5 cycles in RESP -> res_data/res_id stable, req_ready=2'b00 throughout.
//    Then release -> one handshake, op_count+1.
//  5 rst_n low during EXEC -> res_valid=0, op_count=0 the same cycle.
//    After release, the next grant goes to A and no stale result appears.
//  6 Full sweep: every data in 8'h00..8'hFF x amt 0..7 x dir -> matches reference model. op_count wraps correctly when forced near max.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared types and defaults for the rotate arbiter and its rotate datapath.
package rotate_pkg;

    localparam int ROT_DATA_W  = 8;
    localparam int ROT_AMT_W   = $clog2(ROT_DATA_W);
    localparam int ROT_COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } rot_state_t;

    localparam logic ROT_RIGHT = 1'b0;
    localparam logic ROT_LEFT  = 1'b1;

endpackage

// File: rtl/rotate_right_stage.sv
// Combinational log2 barrel rotator: stage k rotates right by 2^k when i_amt[k] is set.
module rotate_right_stage #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amt,
    output logic [DATA_W-1:0] o_data
);

    logic [AMT_W:0][DATA_W-1:0] w_stage;

    assign w_stage[0] = i_data;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign w_stage[k+1] = i_amt[k] ? {w_stage[k][SH-1:0], w_stage[k][DATA_W-1:SH]}
                                       : w_stage[k];
    end

    assign o_data = w_stage[AMT_W];

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one rotate datapath between requesters A and B,
// one transaction in flight, with a completed-operation counter.
module rotate_arbiter
    import rotate_pkg::*;
#(
    parameter int DATA_W  = ROT_DATA_W,
    parameter int AMT_W   = $clog2(DATA_W),
    parameter int COUNT_W = ROT_COUNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_data,
    input  logic [2*AMT_W-1:0]    req_amt,
    input  logic [1:0]            req_dir,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic                  res_id,
    output logic [COUNT_W-1:0]    op_count
);

    rot_state_t r_state;
    rot_state_t w_next_state;

    logic               r_favor_b;
    logic [DATA_W-1:0]  r_op_data;
    logic [AMT_W-1:0]   r_op_amt;
    logic               r_op_id;
    logic [DATA_W-1:0]  r_res_data;
    logic               r_res_id;
    logic [COUNT_W-1:0] r_op_count;

    logic               w_grant_id;
    logic               w_accept;
    logic               w_handshake;
    logic [DATA_W-1:0]  w_sel_data;
    logic [AMT_W-1:0]   w_sel_amt;
    logic               w_sel_dir;
    logic [AMT_W-1:0]   w_eff_amt;
    logic [DATA_W-1:0]  w_rot_data;

    // A lone requester wins outright; the pointer only breaks ties.
    assign w_grant_id = (req_valid == 2'b11) ? r_favor_b : req_valid[1];

    assign w_sel_data = w_grant_id ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    assign w_sel_amt  = w_grant_id ? req_amt[2*AMT_W-1:AMT_W]    : req_amt[AMT_W-1:0];
    assign w_sel_dir  = req_dir[w_grant_id];

    // Left by n equals right by (DATA_W - n) mod DATA_W; with DATA_W a power of two that is -n in AMT_W bits.
    assign w_eff_amt = (w_sel_dir == ROT_LEFT) ? ({AMT_W{1'b0}} - w_sel_amt) : w_sel_amt;

    rotate_right_stage #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_rotate (
        .i_data (r_op_data),
        .i_amt  (r_op_amt),
        .o_data (w_rot_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The rst_n term keeps req_ready low while reset is held even if requests are pending.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_handshake  = 1'b0;
        req_ready    = 2'b00;
        res_valid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (rst_n && (req_valid != 2'b00)) begin
                    w_accept     = 1'b1;
                    req_ready    = w_grant_id ? 2'b10 : 2'b01;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_handshake  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_favor_b  <= 1'b0;
            r_op_data  <= '0;
            r_op_amt   <= '0;
            r_op_id    <= 1'b0;
            r_res_data <= '0;
            r_res_id   <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_op_data <= w_sel_data;
                r_op_amt  <= w_eff_amt;
                r_op_id   <= w_grant_id;
            end
            if (r_state == EXEC) begin
                r_res_data <= w_rot_data;
                r_res_id   <= r_op_id;
            end
            if (w_handshake) begin
                r_op_count <= r_op_count + COUNT_W'(1);
                r_favor_b  <= ~r_res_id;
            end
        end
    end

    assign res_data = r_res_data;
    assign res_id   = r_res_id;
    assign op_count = r_op_count;

endmodule
